// File: rtl/bram_acc_pkg.sv
// Shared types and helpers for the BRAM accumulator.
//   state_e    : controller states
//   SAT_W      : working width of the saturation helper (covers ACC_WIDTH up to 64)
//   sat_signed : clamp a signed value to the signed range of a narrower word
package bram_acc_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2,
        DONE  = 2'd3
    } state_e;

    localparam int unsigned SAT_W = 64;

    // Clamp value to [-2^(data_width-1), 2^(data_width-1)-1]. The result stays SAT_W
    // wide; callers cast it down to data_width bits.
    function automatic logic signed [SAT_W-1:0] sat_signed(
        input logic signed [SAT_W-1:0] value,
        input int unsigned             data_width
    );
        logic signed [SAT_W-1:0] max_v;
        logic signed [SAT_W-1:0] min_v;
        max_v = (64'sd1 <<< (data_width - 1)) - 64'sd1;
        min_v = ~max_v;
        if (value > max_v) begin
            return max_v;
        end else if (value < min_v) begin
            return min_v;
        end
        return value;
    endfunction

endpackage

// File: rtl/bram_accumulator_relu_saturate.sv
// relu_saturate: combinational ReLU-then-saturate of a wide group sum.
//   i_sum     : signed accumulator value, ACC_WIDTH bits
//   i_relu_en : 1 clamps negative sums to 0 before saturation
//   o_result  : signed result saturated to DATA_WIDTH bits
module relu_saturate
    import bram_acc_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ACC_WIDTH  = 44
) (
    input  logic signed [ACC_WIDTH-1:0]  i_sum,
    input  logic                         i_relu_en,
    output logic        [DATA_WIDTH-1:0] o_result
);

    logic signed [SAT_W-1:0] sum_ext;
    logic signed [SAT_W-1:0] clamped;

    always_comb begin
        sum_ext  = SAT_W'(i_sum);
        clamped  = (i_relu_en && sum_ext[SAT_W-1]) ? '0 : sum_ext;
        o_result = DATA_WIDTH'(sat_signed(clamped, DATA_WIDTH));
    end

endmodule

// File: rtl/bram_accumulator.sv
// bram_accumulator: reads the product BRAM sequentially, sums consecutive groups of
// group_len signed products, applies optional ReLU and saturation, and writes one
// word per group into the neuron-output BRAM.
//   clk, reset             : clock, asynchronous active-high reset
//   i_run                  : start pulse (IDLE only)
//   i_num_cnt, i_group_len : products to read, products per group (0 means 1)
//   i_relu_en              : clamp negative sums to 0
//   o_idle/o_busy/o_done   : status; o_done pulses for one cycle
//   o_out_cnt              : output words written in the current/last job
//   ce_p/we_p/addr_p/din_p/qout_p : product BRAM port (read only)
//   ce_o/we_o/addr_o/din_o/qout_o : output BRAM port (write only)
module bram_accumulator
    import bram_acc_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 12,
    parameter int unsigned ACC_WIDTH  = DATA_WIDTH + ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  i_run,
    input  logic [ADDR_WIDTH-1:0] i_num_cnt,
    input  logic [ADDR_WIDTH-1:0] i_group_len,
    input  logic                  i_relu_en,
    output logic                  o_idle,
    output logic                  o_busy,
    output logic                  o_done,
    output logic [ADDR_WIDTH-1:0] o_out_cnt,
    output logic                  ce_p,
    output logic                  we_p,
    output logic [ADDR_WIDTH-1:0] addr_p,
    output logic [DATA_WIDTH-1:0] din_p,
    input  logic [DATA_WIDTH-1:0] qout_p,
    output logic                  ce_o,
    output logic                  we_o,
    output logic [ADDR_WIDTH-1:0] addr_o,
    output logic [DATA_WIDTH-1:0] din_o,
    input  logic [DATA_WIDTH-1:0] qout_o
);

    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = ADDR_WIDTH'(1);

    state_e state_q, state_d;

    logic [ADDR_WIDTH-1:0] num_cnt_q, num_cnt_d;
    logic [ADDR_WIDTH-1:0] group_len_q, group_len_d;
    logic                  relu_en_q, relu_en_d;
    logic [ADDR_WIDTH-1:0] rd_cnt_q, rd_cnt_d;
    logic [ADDR_WIDTH-1:0] elem_cnt_q, elem_cnt_d;
    logic [ADDR_WIDTH-1:0] wr_cnt_q, wr_cnt_d;
    logic                  rd_valid_q, rd_valid_d;
    logic                  rd_last_q, rd_last_d;
    logic                  wr_valid_q, wr_valid_d;
    logic [DATA_WIDTH-1:0] out_reg_q, out_reg_d;

    logic signed [ACC_WIDTH-1:0] acc_q, acc_d;
    logic signed [ACC_WIDTH-1:0] prod_ext;
    logic signed [ACC_WIDTH-1:0] acc_next;

    logic                  run_accept;
    logic                  rd_is_last;
    logic                  group_close;
    logic [DATA_WIDTH-1:0] sat_result;

    logic unused_qout_o;
    assign unused_qout_o = ^qout_o;

    assign rd_is_last = (rd_cnt_q == num_cnt_q - ADDR_ONE);

    // Controller
    always_comb begin
        state_d     = state_q;
        num_cnt_d   = num_cnt_q;
        group_len_d = group_len_q;
        relu_en_d   = relu_en_q;
        rd_cnt_d    = rd_cnt_q;
        run_accept  = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (i_run) begin
                    run_accept  = 1'b1;
                    num_cnt_d   = i_num_cnt;
                    group_len_d = (i_group_len == '0) ? ADDR_ONE : i_group_len;
                    relu_en_d   = i_relu_en;
                    rd_cnt_d    = '0;
                    state_d     = (i_num_cnt == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                if (rd_is_last) begin
                    rd_cnt_d = '0;
                    state_d  = FLUSH;
                end else begin
                    rd_cnt_d = rd_cnt_q + ADDR_ONE;
                end
            end
            FLUSH: begin
                // Once the read pipe is empty no further group can close; a write still
                // flagged in wr_valid_q completes on this same edge.
                if (!rd_valid_q) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Datapath
    always_comb begin
        rd_valid_d = (state_q == RUN);
        rd_last_d  = (state_q == RUN) && rd_is_last;

        prod_ext = ACC_WIDTH'(signed'(qout_p));
        acc_next = (elem_cnt_q == '0) ? prod_ext : acc_q + prod_ext;

        // A group closes on its last element or on the job's final product, which
        // flushes a partial trailing group.
        group_close = rd_valid_q && ((elem_cnt_q == group_len_q - ADDR_ONE) || rd_last_q);

        acc_d = rd_valid_q ? acc_next : acc_q;

        elem_cnt_d = elem_cnt_q;
        if (run_accept) begin
            elem_cnt_d = '0;
        end else if (rd_valid_q) begin
            elem_cnt_d = group_close ? '0 : elem_cnt_q + ADDR_ONE;
        end

        out_reg_d  = group_close ? sat_result : out_reg_q;
        wr_valid_d = group_close;

        wr_cnt_d = wr_cnt_q;
        if (run_accept) begin
            wr_cnt_d = '0;
        end else if (wr_valid_q) begin
            wr_cnt_d = wr_cnt_q + ADDR_ONE;
        end
    end

    relu_saturate #(
        .DATA_WIDTH (DATA_WIDTH),
        .ACC_WIDTH  (ACC_WIDTH)
    ) u_relu_saturate (
        .i_sum     (acc_next),
        .i_relu_en (relu_en_q),
        .o_result  (sat_result)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            num_cnt_q   <= '0;
            group_len_q <= '0;
            relu_en_q   <= 1'b0;
            rd_cnt_q    <= '0;
            elem_cnt_q  <= '0;
            wr_cnt_q    <= '0;
            rd_valid_q  <= 1'b0;
            rd_last_q   <= 1'b0;
            wr_valid_q  <= 1'b0;
            out_reg_q   <= '0;
            acc_q       <= '0;
        end else begin
            state_q     <= state_d;
            num_cnt_q   <= num_cnt_d;
            group_len_q <= group_len_d;
            relu_en_q   <= relu_en_d;
            rd_cnt_q    <= rd_cnt_d;
            elem_cnt_q  <= elem_cnt_d;
            wr_cnt_q    <= wr_cnt_d;
            rd_valid_q  <= rd_valid_d;
            rd_last_q   <= rd_last_d;
            wr_valid_q  <= wr_valid_d;
            out_reg_q   <= out_reg_d;
            acc_q       <= acc_d;
        end
    end

    assign o_idle    = (state_q == IDLE);
    assign o_busy    = (state_q == RUN) || (state_q == FLUSH);
    assign o_done    = (state_q == DONE);
    assign o_out_cnt = wr_cnt_q;

    assign ce_p   = (state_q == RUN);
    assign we_p   = 1'b0;
    assign addr_p = rd_cnt_q;
    assign din_p  = '0;

    assign ce_o   = wr_valid_q;
    assign we_o   = wr_valid_q;
    assign addr_o = wr_cnt_q;
    assign din_o  = out_reg_q;

endmodule

// File: tb/tb_bram_accumulator.sv
// Self-checking bench for bram_accumulator: a behavioural product BRAM, a per-job
// reference model computing group sums with plain 64-bit arithmetic, and checks on
// write data, addresses, write cycles, read sequencing, done timing and aborts.
module tb_bram_accumulator;

    localparam int unsigned DW = 32;
    localparam int unsigned AW = 12;

    logic          clk;
    logic          reset;
    logic          i_run;
    logic [AW-1:0] i_num_cnt;
    logic [AW-1:0] i_group_len;
    logic          i_relu_en;
    logic          o_idle;
    logic          o_busy;
    logic          o_done;
    logic [AW-1:0] o_out_cnt;
    logic          ce_p;
    logic          we_p;
    logic [AW-1:0] addr_p;
    logic [DW-1:0] din_p;
    logic [DW-1:0] qout_p;
    logic          ce_o;
    logic          we_o;
    logic [AW-1:0] addr_o;
    logic [DW-1:0] din_o;
    logic [DW-1:0] qout_o;

    logic [DW-1:0] prod_mem [4096];

    int n_checks;
    int n_fail;

    bram_accumulator #(
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .i_run       (i_run),
        .i_num_cnt   (i_num_cnt),
        .i_group_len (i_group_len),
        .i_relu_en   (i_relu_en),
        .o_idle      (o_idle),
        .o_busy      (o_busy),
        .o_done      (o_done),
        .o_out_cnt   (o_out_cnt),
        .ce_p        (ce_p),
        .we_p        (we_p),
        .addr_p      (addr_p),
        .din_p       (din_p),
        .qout_p      (qout_p),
        .ce_o        (ce_o),
        .we_o        (we_o),
        .addr_o      (addr_o),
        .din_o       (din_o),
        .qout_o      (qout_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Product BRAM: registered read, one cycle latency.
    always @(posedge clk) begin
        if (ce_p) qout_p <= prod_mem[addr_p];
    end

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Runs one job; glitch>0 pulses i_run during that cycle of the job.
    task automatic run_job(input string name, input int num, input int glen, input bit relu,
                           input int glitch);
        longint        exp_data[$];
        int            exp_cyc[$];
        logic [DW-1:0] got_data[$];
        logic [AW-1:0] got_addr[$];
        int            got_cyc[$];
        int            g, cnt, cyc, done_cyc, rd_err, out_cnt_done, n_cmp;
        longint        s, v;
        logic [63:0]   tmp;

        g = (glen == 0) ? 1 : glen;
        s = 0;
        cnt = 0;
        for (int k = 0; k < num; k++) begin
            s += longint'($signed(prod_mem[k]));
            cnt++;
            if (cnt == g || k == num - 1) begin
                v = s;
                if (relu && v < 0) v = 0;
                if (v > 64'sd2147483647) v = 64'sd2147483647;
                if (v < -64'sd2147483648) v = -64'sd2147483648;
                exp_data.push_back(v);
                exp_cyc.push_back(k + 3);
                s = 0;
                cnt = 0;
            end
        end

        @(negedge clk);
        i_num_cnt   = AW'(num);
        i_group_len = AW'(glen);
        i_relu_en   = relu;
        i_run       = 1'b1;
        @(posedge clk);
        #1 i_run = 1'b0;

        cyc = 0;
        done_cyc = -1;
        rd_err = 0;
        out_cnt_done = -1;
        while (done_cyc < 0 && cyc < num + 12) begin
            @(negedge clk);
            cyc++;
            i_run = (cyc == glitch);
            if (ce_p !== (cyc <= num)) rd_err++;
            else if (ce_p && addr_p !== AW'(cyc - 1)) rd_err++;
            if (ce_o !== we_o) rd_err++;
            if (we_o === 1'b1) begin
                got_data.push_back(din_o);
                got_addr.push_back(addr_o);
                got_cyc.push_back(cyc);
            end
            if (o_done === 1'b1) begin
                done_cyc = cyc;
                out_cnt_done = int'(o_out_cnt);
            end
        end
        i_run = 1'b0;

        check_eq($sformatf("%s done_cyc", name), 64'(done_cyc), 64'((num == 0) ? 1 : num + 3));
        check_eq($sformatf("%s rd_seq_errs", name), 64'(rd_err), 64'd0);
        check_eq($sformatf("%s n_writes", name), 64'(got_data.size()), 64'(exp_data.size()));
        check_eq($sformatf("%s out_cnt", name), 64'(out_cnt_done), 64'(exp_data.size()));
        n_cmp = (got_data.size() < exp_data.size()) ? got_data.size() : exp_data.size();
        for (int i = 0; i < n_cmp; i++) begin
            tmp = exp_data[i];
            check_eq($sformatf("%s wr%0d addr", name, i), 64'(got_addr[i]), 64'(i));
            check_eq($sformatf("%s wr%0d data", name, i), 64'(got_data[i]), 64'(tmp[31:0]));
            check_eq($sformatf("%s wr%0d cyc", name, i), 64'(got_cyc[i]), 64'(exp_cyc[i]));
        end
        @(negedge clk);
        check_eq($sformatf("%s idle_after", name), 64'(o_idle), 64'd1);
    endtask

    function automatic logic [DW-1:0] rand_prod();
        case ($urandom_range(0, 4))
            0:       return DW'($urandom_range(0, 200)) - DW'(100);
            1:       return 32'h7FFF_FFFF;
            2:       return 32'h8000_0000;
            default: return DW'($urandom);
        endcase
    endfunction

    initial begin
        int num, wr_seen;

        n_checks    = 0;
        n_fail      = 0;
        reset       = 1'b1;
        i_run       = 1'b0;
        i_num_cnt   = '0;
        i_group_len = '0;
        i_relu_en   = 1'b0;
        qout_o      = '0;
        for (int i = 0; i < 4096; i++) prod_mem[i] = '0;

        repeat (3) @(negedge clk);
        check_eq("rst o_idle", 64'(o_idle), 64'd1);
        check_eq("rst o_busy", 64'(o_busy), 64'd0);
        check_eq("rst o_done", 64'(o_done), 64'd0);
        check_eq("rst o_out_cnt", 64'(o_out_cnt), 64'd0);
        check_eq("rst ce_p/we_p", 64'({ce_p, we_p}), 64'd0);
        check_eq("rst ce_o/we_o", 64'({ce_o, we_o}), 64'd0);
        check_eq("rst addr_p/addr_o", 64'({addr_p, addr_o}), 64'd0);
        check_eq("rst din_p/din_o", 64'({din_p, din_o}), 64'd0);
        reset = 1'b0;

        // Plain sums: 10 and 26.
        for (int i = 0; i < 8; i++) prod_mem[i] = DW'(i + 1);
        run_job("seq8", 8, 4, 1'b0, 0);

        // ReLU clamp plus partial trailing group.
        prod_mem[0] = -32'sd5; prod_mem[1] = -32'sd5; prod_mem[2] = -32'sd5;
        prod_mem[3] = -32'sd5; prod_mem[4] = 32'sd3;  prod_mem[5] = 32'sd4;
        run_job("relu6", 6, 4, 1'b1, 0);

        // Group length 0 behaves as 1.
        prod_mem[0] = 32'sd7; prod_mem[1] = -32'sd2; prod_mem[2] = 32'sd9;
        run_job("glen0", 3, 0, 1'b0, 0);

        // Empty job.
        run_job("empty", 0, 4, 1'b0, 0);

        // Positive and negative saturation.
        prod_mem[0] = 32'h7FFF_FFFF; prod_mem[1] = 32'h0000_0010;
        prod_mem[2] = 32'h8000_0000; prod_mem[3] = 32'hFFFF_FFFF;
        run_job("sat", 4, 2, 1'b0, 0);

        // Same job twice, the second with a stray i_run mid-run.
        for (int i = 0; i < 20; i++) prod_mem[i] = rand_prod();
        run_job("clean", 20, 3, 1'b1, 0);
        run_job("glitch", 20, 3, 1'b1, 7);

        // Abort a long job with reset.
        for (int i = 0; i < 100; i++) prod_mem[i] = rand_prod();
        @(negedge clk);
        i_num_cnt   = AW'(100);
        i_group_len = AW'(5);
        i_relu_en   = 1'b0;
        i_run       = 1'b1;
        @(posedge clk);
        #1 i_run = 1'b0;
        repeat (20) @(negedge clk);
        reset = 1'b1;
        #1;
        check_eq("abort o_idle", 64'(o_idle), 64'd1);
        check_eq("abort o_busy", 64'(o_busy), 64'd0);
        check_eq("abort o_out_cnt", 64'(o_out_cnt), 64'd0);
        repeat (3) @(negedge clk);
        reset = 1'b0;
        wr_seen = 0;
        repeat (30) begin
            @(negedge clk);
            if (we_o !== 1'b0 || ce_o !== 1'b0 || ce_p !== 1'b0) wr_seen++;
        end
        check_eq("abort no_access", 64'(wr_seen), 64'd0);

        // Randomized jobs.
        for (int j = 0; j < 12; j++) begin
            num = $urandom_range(1, 40);
            for (int i = 0; i < num; i++) prod_mem[i] = rand_prod();
            run_job($sformatf("rnd%0d", j), num, $urandom_range(0, 8), 1'($urandom_range(0, 1)),
                    ($urandom_range(0, 1) == 1) ? $urandom_range(1, num) : 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
